// File: rtl/rk4_step_engine.sv
// RK4 integrator datapath for dy/dx = (x - y)/2: one stage per clock (k1..k4, update),
// shared f/mulH evaluator, step counter with limit flags, and LD-latched result registers.
module rk4_step_engine #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int CW   = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CLR,
    input  logic                SEL,
    input  logic                LD,
    input  logic signed [W-1:0] H_IN,
    input  logic signed [W-1:0] X0,
    input  logic signed [W-1:0] Y0,
    input  logic [CW-1:0]       N_STEPS,
    output logic signed [W-1:0] X_OUT,
    output logic signed [W-1:0] Y_OUT,
    output logic [CW-1:0]       CNT,
    output logic                LIMIT,
    output logic                LOW_LIM,
    output logic                BUSY,
    output logic                STEP_DONE
);

    // state  | meaning
    // S_IDLE | waiting for SEL with CNT below N_STEPS
    // S_K1   | k1 evaluated, registered on exit
    // S_K2   | k2 evaluated from k1
    // S_K3   | k3 evaluated from k2
    // S_K4   | k4 evaluated from k3
    // S_UPD  | x/y/CNT update, continue or return to idle
    typedef enum logic [2:0] {S_IDLE, S_K1, S_K2, S_K3, S_K4, S_UPD} stage_t;

    localparam logic signed [W+2:0] SIX = (W+3)'(6);

    stage_t              stage_q, stage_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d;
    logic signed [W-1:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d, k4_q, k4_d;
    logic signed [W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                step_done_q, step_done_d;

    logic signed [W-1:0]   h_half, op_a, op_b, diff, f_val, k_new;
    logic signed [2*W-1:0] prod;
    logic signed [W+2:0]   k1_x, k2_x, k3_x, k4_x, k_sum, quot;
    logic [CW:0]           cnt_nxt;
    logic                  unused_bits;

    // One f/mulH evaluator shared by all four k stages; only the operands change.
    always_comb begin
        h_half = H_IN >>> 1;
        op_a   = x_q;
        op_b   = y_q;
        case (stage_q)
            S_K2: begin
                op_a = x_q + h_half;
                op_b = y_q + (k1_q >>> 1);
            end
            S_K3: begin
                op_a = x_q + h_half;
                op_b = y_q + (k2_q >>> 1);
            end
            S_K4: begin
                op_a = x_q + H_IN;
                op_b = y_q + k3_q;
            end
            default: begin
                op_a = x_q;
                op_b = y_q;
            end
        endcase
        diff  = op_a - op_b;
        f_val = diff >>> 1;
        prod  = H_IN * f_val;
        k_new = prod[FRAC+W-1:FRAC];
    end

    always_comb begin
        k1_x    = {{3{k1_q[W-1]}}, k1_q};
        k2_x    = {{3{k2_q[W-1]}}, k2_q};
        k3_x    = {{3{k3_q[W-1]}}, k3_q};
        k4_x    = {{3{k4_q[W-1]}}, k4_q};
        k_sum   = k1_x + k2_x + k2_x + k3_x + k3_x + k4_x;
        quot    = k_sum / SIX;
        cnt_nxt = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    end

    assign unused_bits = ^{prod[FRAC-1:0], prod[2*W-1:FRAC+W], quot[W+2:W]};

    always_comb begin
        stage_d     = stage_q;
        x_d         = x_q;
        y_d         = y_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        k3_d        = k3_q;
        k4_d        = k4_q;
        cnt_d       = cnt_q;
        step_done_d = 1'b0;
        x_out_d     = LD ? x_q : x_out_q;
        y_out_d     = LD ? y_q : y_out_q;

        case (stage_q)
            S_IDLE: if (SEL && (cnt_q < N_STEPS)) stage_d = S_K1;
            S_K1: begin
                k1_d    = k_new;
                stage_d = S_K2;
            end
            S_K2: begin
                k2_d    = k_new;
                stage_d = S_K3;
            end
            S_K3: begin
                k3_d    = k_new;
                stage_d = S_K4;
            end
            S_K4: begin
                k4_d    = k_new;
                stage_d = S_UPD;
            end
            S_UPD: begin
                x_d         = x_q + H_IN;
                y_d         = y_q + quot[W-1:0];
                cnt_d       = cnt_nxt[CW-1:0];
                step_done_d = 1'b1;
                stage_d     = (SEL && (cnt_nxt < {1'b0, N_STEPS})) ? S_K1 : S_IDLE;
            end
            default: stage_d = S_IDLE;
        endcase

        if (CLR) begin
            stage_d     = S_IDLE;
            x_d         = X0;
            y_d         = Y0;
            k1_d        = '0;
            k2_d        = '0;
            k3_d        = '0;
            k4_d        = '0;
            cnt_d       = '0;
            step_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= '0;
            k4_q        <= '0;
            cnt_q       <= '0;
            step_done_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
        end else begin
            stage_q     <= stage_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            k3_q        <= k3_d;
            k4_q        <= k4_d;
            cnt_q       <= cnt_d;
            step_done_q <= step_done_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
        end
    end

    assign X_OUT     = x_out_q;
    assign Y_OUT     = y_out_q;
    assign CNT       = cnt_q;
    assign LIMIT     = (cnt_q == N_STEPS);
    assign LOW_LIM   = (cnt_q == '0);
    assign BUSY      = (stage_q != S_IDLE);
    assign STEP_DONE = step_done_q;

endmodule

// File: tb/tb_rk4_step_engine.sv
// Directed bench for rk4_step_engine: hand-computed RK4 step, counting, abort, pause and N=0 cases.
module tb_rk4_step_engine;

    logic               CLK = 1'b0;
    logic               RST_N, CLR, SEL, LD;
    logic signed [15:0] H_IN, X0, Y0;
    logic [7:0]         N_STEPS;
    logic signed [15:0] X_OUT, Y_OUT;
    logic [7:0]         CNT;
    logic               LIMIT, LOW_LIM, BUSY, STEP_DONE;

    int checks = 0;
    int fails  = 0;

    rk4_step_engine #(.W(16), .FRAC(8), .CW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .SEL(SEL), .LD(LD),
        .H_IN(H_IN), .X0(X0), .Y0(Y0), .N_STEPS(N_STEPS),
        .X_OUT(X_OUT), .Y_OUT(Y_OUT), .CNT(CNT), .LIMIT(LIMIT),
        .LOW_LIM(LOW_LIM), .BUSY(BUSY), .STEP_DONE(STEP_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CLR = 1'b0; SEL = 1'b0; LD = 1'b0;
        H_IN = 16'sd0; X0 = 16'sd5; Y0 = 16'sd7; N_STEPS = 8'd3;
        #2;
        checks++; if (CNT !== 8'd0 || BUSY !== 1'b0 || STEP_DONE !== 1'b0) begin
            fails++; $display("FAIL reset_init cnt=%0d busy=%0b done=%0b want 0/0/0", CNT, BUSY, STEP_DONE);
        end
        checks++; if (LOW_LIM !== 1'b1 || LIMIT !== 1'b0) begin
            fails++; $display("FAIL reset_init_flags low=%0b lim=%0b want 1/0", LOW_LIM, LIMIT);
        end
        tick();
        RST_N = 1'b1;
        tick();
        do_clr();
        LD = 1'b1; SEL = 1'b1;
        tick();
        LD = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        checks++; if (BUSY !== 1'b1 || CNT !== 8'd1 || X_OUT !== 16'sd5) begin
            fails++; $display("FAIL reset_prerun busy=%0b cnt=%0d xout=%0d want 1/1/5", BUSY, CNT, X_OUT);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (CNT !== 8'd0 || BUSY !== 1'b0 || STEP_DONE !== 1'b0 || X_OUT !== 16'sd0 || Y_OUT !== 16'sd0) begin
            fails++; $display("FAIL reset_async cnt=%0d busy=%0b done=%0b x=%0d y=%0d want all 0", CNT, BUSY, STEP_DONE, X_OUT, Y_OUT);
        end
        checks++; if (LOW_LIM !== 1'b1 || LIMIT !== 1'b0) begin
            fails++; $display("FAIL reset_async_flags low=%0b lim=%0b want 1/0", LOW_LIM, LIMIT);
        end
        SEL = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single_step();
        H_IN = 16'sd128; X0 = 16'sd0; Y0 = 16'sd256; N_STEPS = 8'd1;
        do_clr();
        SEL = 1'b1;
        tick();
        checks++; if (BUSY !== 1'b1) begin
            fails++; $display("FAIL single_busy got %0b want 1", BUSY);
        end
        tick();
        checks++; if (dut.k1_q !== -16'sd64) begin
            fails++; $display("FAIL single_k1 got %0d want -64", dut.k1_q);
        end
        tick();
        checks++; if (dut.k2_q !== -16'sd40) begin
            fails++; $display("FAIL single_k2 got %0d want -40", dut.k2_q);
        end
        tick();
        checks++; if (dut.k3_q !== -16'sd43) begin
            fails++; $display("FAIL single_k3 got %0d want -43", dut.k3_q);
        end
        tick();
        checks++; if (dut.k4_q !== -16'sd22) begin
            fails++; $display("FAIL single_k4 got %0d want -22", dut.k4_q);
        end
        LD = 1'b1;
        tick();
        LD = 1'b0; SEL = 1'b0;
        checks++; if (X_OUT !== 16'sd0 || Y_OUT !== 16'sd256) begin
            fails++; $display("FAIL single_ld_preupd x=%0d y=%0d want 0/256", X_OUT, Y_OUT);
        end
        checks++; if (CNT !== 8'd1 || LIMIT !== 1'b1 || STEP_DONE !== 1'b1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL single_done cnt=%0d lim=%0b done=%0b busy=%0b want 1/1/1/0", CNT, LIMIT, STEP_DONE, BUSY);
        end
        LD = 1'b1;
        tick();
        LD = 1'b0;
        checks++; if (X_OUT !== 16'sd128 || Y_OUT !== 16'sd214) begin
            fails++; $display("FAIL single_result x=%0d y=%0d want 128/214", X_OUT, Y_OUT);
        end
        checks++; if (STEP_DONE !== 1'b0) begin
            fails++; $display("FAIL single_pulse_width got %0b want 0", STEP_DONE);
        end
    endtask

    task automatic test_multi_step();
        H_IN = 16'sd0; X0 = 16'sd100; Y0 = 16'sd50; N_STEPS = 8'd4;
        do_clr();
        checks++; if (LOW_LIM !== 1'b1 || LIMIT !== 1'b0) begin
            fails++; $display("FAIL multi_start low=%0b lim=%0b want 1/0", LOW_LIM, LIMIT);
        end
        SEL = 1'b1;
        tick();
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++; if (CNT !== 8'(e / 5) || STEP_DONE !== (e % 5 == 0) || BUSY !== (e < 20)) begin
                fails++; $display("FAIL multi_edge%0d cnt=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                                  e, CNT, STEP_DONE, BUSY, e / 5, (e % 5 == 0), (e < 20));
            end
        end
        checks++; if (LIMIT !== 1'b1) begin
            fails++; $display("FAIL multi_limit got %0b want 1", LIMIT);
        end
        for (int e = 0; e < 5; e++) begin
            tick();
            checks++; if (CNT !== 8'd4 || BUSY !== 1'b0 || STEP_DONE !== 1'b0) begin
                fails++; $display("FAIL multi_hold cnt=%0d busy=%0b done=%0b want 4/0/0", CNT, BUSY, STEP_DONE);
            end
        end
        SEL = 1'b0; LD = 1'b1;
        tick();
        LD = 1'b0;
        checks++; if (X_OUT !== 16'sd100 || Y_OUT !== 16'sd50) begin
            fails++; $display("FAIL multi_xy x=%0d y=%0d want 100/50", X_OUT, Y_OUT);
        end
    endtask

    task automatic test_clr_mid_step();
        H_IN = 16'sd128; X0 = 16'sd0; Y0 = 16'sd256; N_STEPS = 8'd2;
        do_clr();
        SEL = 1'b1;
        tick(); tick(); tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0; LD = 1'b1;
        checks++; if (BUSY !== 1'b0 || CNT !== 8'd0 || STEP_DONE !== 1'b0 || dut.k1_q !== 16'sd0) begin
            fails++; $display("FAIL clr_abort busy=%0b cnt=%0d done=%0b k1=%0d want 0/0/0/0", BUSY, CNT, STEP_DONE, dut.k1_q);
        end
        tick();
        LD = 1'b0;
        checks++; if (BUSY !== 1'b1 || X_OUT !== 16'sd0 || Y_OUT !== 16'sd256) begin
            fails++; $display("FAIL clr_restart busy=%0b x=%0d y=%0d want 1/0/256", BUSY, X_OUT, Y_OUT);
        end
        for (int e = 1; e <= 10; e++) tick();
        checks++; if (CNT !== 8'd2 || LIMIT !== 1'b1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL clr_rerun cnt=%0d lim=%0b busy=%0b want 2/1/0", CNT, LIMIT, BUSY);
        end
        SEL = 1'b0;
    endtask

    task automatic test_sel_drop();
        H_IN = 16'sd0; X0 = 16'sd10; Y0 = 16'sd20; N_STEPS = 8'd3;
        do_clr();
        SEL = 1'b1;
        tick(); tick();
        SEL = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (CNT !== 8'd1 || BUSY !== 1'b0 || LIMIT !== 1'b0 || LOW_LIM !== 1'b0) begin
            fails++; $display("FAIL drop_pause cnt=%0d busy=%0b lim=%0b low=%0b want 1/0/0/0", CNT, BUSY, LIMIT, LOW_LIM);
        end
        tick();
        checks++; if (CNT !== 8'd1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL drop_hold cnt=%0d busy=%0b want 1/0", CNT, BUSY);
        end
        SEL = 1'b1;
        tick();
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 9) begin
                checks++; if (CNT !== 8'd2 || BUSY !== 1'b1) begin
                    fails++; $display("FAIL drop_edge9 cnt=%0d busy=%0b want 2/1", CNT, BUSY);
                end
            end
        end
        checks++; if (CNT !== 8'd3 || LIMIT !== 1'b1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL drop_resume cnt=%0d lim=%0b busy=%0b want 3/1/0", CNT, LIMIT, BUSY);
        end
        SEL = 1'b0;
    endtask

    task automatic test_n_zero();
        H_IN = 16'sd128; X0 = 16'sd33; Y0 = 16'sd44; N_STEPS = 8'd0;
        CLR = 1'b1; LD = 1'b1;
        tick();
        CLR = 1'b0; LD = 1'b0;
        checks++; if (X_OUT !== 16'sd10 || Y_OUT !== 16'sd20) begin
            fails++; $display("FAIL nzero_ld_preclr x=%0d y=%0d want 10/20", X_OUT, Y_OUT);
        end
        checks++; if (LIMIT !== 1'b1 || LOW_LIM !== 1'b1) begin
            fails++; $display("FAIL nzero_flags lim=%0b low=%0b want 1/1", LIMIT, LOW_LIM);
        end
        SEL = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            checks++; if (BUSY !== 1'b0 || CNT !== 8'd0) begin
                fails++; $display("FAIL nzero_idle busy=%0b cnt=%0d want 0/0", BUSY, CNT);
            end
        end
        LD = 1'b1;
        tick();
        LD = 1'b0; SEL = 1'b0;
        checks++; if (X_OUT !== 16'sd33 || Y_OUT !== 16'sd44) begin
            fails++; $display("FAIL nzero_xy x=%0d y=%0d want 33/44", X_OUT, Y_OUT);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_multi_step();
        test_clr_mid_step();
        test_sel_drop();
        test_n_zero();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
